// File: rtl/id_hazard_issue_ctrl_pkg.sv
// Shared definitions for the ID-stage issue controller and the ID/EX register:
// FSM encoding, RISC-V opcodes that matter for operand use, bubble word, bundle widths.
package id_hazard_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int INSN_W     = 32;
  localparam int ALUSRC_W   = 2;
  localparam int ALUOP_W    = 2;
  localparam int MEMTOREG_W = 2;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/id_hazard_issue_ctrl_hazard_detect.sv
// Combinational load-use detector: flags an IF/ID instruction that reads the
// register a load currently in EX is about to write.
module hazard_detect
  import id_hazard_issue_ctrl_pkg::*;
(
  input  logic [INSN_W-1:0]     insn,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  unused_bits;

  assign opcode = insn[6:0];
  assign rs1    = insn[19:15];
  assign rs2    = insn[24:20];

  // U-type and JAL carry immediate bits where rs1 would sit
  assign rs1_used = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
  assign rs2_used = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

  assign unused_bits = ^{insn[31:25], insn[14:7]};

endmodule

// File: rtl/id_hazard_issue_ctrl.sv
// Issue controller on the write side of ID/EX: forwards the decoded bundle or a
// bubble, drives PC / IF/ID enables, and counts stall and flush events.
module id_hazard_issue_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16,
  parameter logic [31:0] NOP_INSN     = id_hazard_issue_ctrl_pkg::NOP_INSN
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [id_hazard_issue_ctrl_pkg::INSN_W-1:0]      ip_Instruction,
  input  logic [id_hazard_issue_ctrl_pkg::ALUSRC_W-1:0]    ip_ALUSrc,
  input  logic [id_hazard_issue_ctrl_pkg::ALUOP_W-1:0]     ip_ALUOp,
  input  logic                                             ip_MemRead,
  input  logic                                             ip_MemWrite,
  input  logic [id_hazard_issue_ctrl_pkg::MEMTOREG_W-1:0]  ip_MemtoReg,
  input  logic                                             ip_RegWrite,
  input  logic                                             ip_Imm_signal,
  input  logic                                             ex_MemRead,
  input  logic [id_hazard_issue_ctrl_pkg::REG_ADDR_W-1:0]  ex_rd,
  input  logic                                             ex_branch_taken,
  input  logic                                             ext_stall,
  output logic [id_hazard_issue_ctrl_pkg::INSN_W-1:0]      op_Instruction,
  output logic [id_hazard_issue_ctrl_pkg::ALUSRC_W-1:0]    op_ALUSrc,
  output logic [id_hazard_issue_ctrl_pkg::ALUOP_W-1:0]     op_ALUOp,
  output logic                                             op_MemRead,
  output logic                                             op_MemWrite,
  output logic [id_hazard_issue_ctrl_pkg::MEMTOREG_W-1:0]  op_MemtoReg,
  output logic                                             op_RegWrite,
  output logic                                             op_Imm_signal,
  output logic                                             pc_write,
  output logic                                             if_id_write,
  output logic                                             if_id_flush,
  output logic [1:0]                                       state,
  output logic [CNT_W-1:0]                                 stall_count,
  output logic [CNT_W-1:0]                                 flush_count
);
  import id_hazard_issue_ctrl_pkg::*;

  localparam logic [2:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_e           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             load_use;
  logic             pass;

  hazard_detect u_hazard_detect (
    .insn        (ip_Instruction),
    .ex_mem_read (ex_MemRead),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pass        = 1'b0;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          if (ex_branch_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
          end else if (flush_cnt_q == 3'd0) begin
            state_d = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        // RUN, LU_STALL and HOLD share one rule set; LU_STALL only masks the hazard
        default: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            pc_write    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FLUSH_RELOAD;
            end else begin
              state_d = ST_RUN;
            end
          end else if (ext_stall) begin
            state_d = ST_HOLD;
          end else if (load_use && (state_q != ST_LU_STALL)) begin
            state_d = ST_LU_STALL;
          end else begin
            pass        = 1'b1;
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_d     = ST_RUN;
          end
        end
      endcase
    end
  end

  assign op_Instruction = pass ? ip_Instruction : NOP_INSN;
  assign op_ALUSrc      = pass ? ip_ALUSrc      : '0;
  assign op_ALUOp       = pass ? ip_ALUOp       : '0;
  assign op_MemRead     = pass ? ip_MemRead     : 1'b0;
  assign op_MemWrite    = pass ? ip_MemWrite    : 1'b0;
  assign op_MemtoReg    = pass ? ip_MemtoReg    : '0;
  assign op_RegWrite    = pass ? ip_RegWrite    : 1'b0;
  assign op_Imm_signal  = pass ? ip_Imm_signal  : 1'b0;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (ex_branch_taken && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_id_hazard_issue_ctrl.sv
// Bench for id_hazard_issue_ctrl: two instances (3-cycle flush / 16-bit counters and
// 1-cycle flush / 3-bit counters) compared every cycle against an event-level model.
module tb_id_hazard_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0]  O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
  localparam logic [6:0]  O_R = 7'b0110011, O_S = 7'b0100011, O_B = 7'b1100011;
  localparam logic [6:0]  O_I = 7'b0010011, O_LD = 7'b0000011;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [31:0] ip_Instruction;
  logic [1:0]  ip_ALUSrc, ip_ALUOp, ip_MemtoReg;
  logic        ip_MemRead, ip_MemWrite, ip_RegWrite, ip_Imm_signal;
  logic        ex_MemRead, ex_branch_taken, ext_stall;
  logic [4:0]  ex_rd;

  logic [31:0] a_insn, b_insn;
  logic [1:0]  a_alusrc, b_alusrc, a_aluop, b_aluop, a_m2r, b_m2r;
  logic        a_mr, b_mr, a_mw, b_mw, a_rw, b_rw, a_imm, b_imm;
  logic        a_pcw, b_pcw, a_ifw, b_ifw, a_ifl, b_ifl;
  logic [1:0]  a_state, b_state;
  logic [15:0] a_stall, a_flush;
  logic [2:0]  b_stall, b_flush;

  id_hazard_issue_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16), .NOP_INSN(NOP)) dut_a (
    .clk(clk), .reset(reset), .ip_Instruction(ip_Instruction), .ip_ALUSrc(ip_ALUSrc),
    .ip_ALUOp(ip_ALUOp), .ip_MemRead(ip_MemRead), .ip_MemWrite(ip_MemWrite),
    .ip_MemtoReg(ip_MemtoReg), .ip_RegWrite(ip_RegWrite), .ip_Imm_signal(ip_Imm_signal),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ext_stall(ext_stall), .op_Instruction(a_insn), .op_ALUSrc(a_alusrc), .op_ALUOp(a_aluop),
    .op_MemRead(a_mr), .op_MemWrite(a_mw), .op_MemtoReg(a_m2r), .op_RegWrite(a_rw),
    .op_Imm_signal(a_imm), .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_ifl),
    .state(a_state), .stall_count(a_stall), .flush_count(a_flush)
  );

  id_hazard_issue_ctrl #(.FLUSH_CYCLES(1), .CNT_W(3), .NOP_INSN(NOP)) dut_b (
    .clk(clk), .reset(reset), .ip_Instruction(ip_Instruction), .ip_ALUSrc(ip_ALUSrc),
    .ip_ALUOp(ip_ALUOp), .ip_MemRead(ip_MemRead), .ip_MemWrite(ip_MemWrite),
    .ip_MemtoReg(ip_MemtoReg), .ip_RegWrite(ip_RegWrite), .ip_Imm_signal(ip_Imm_signal),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ext_stall(ext_stall), .op_Instruction(b_insn), .op_ALUSrc(b_alusrc), .op_ALUOp(b_aluop),
    .op_MemRead(b_mr), .op_MemWrite(b_mw), .op_MemtoReg(b_m2r), .op_RegWrite(b_rw),
    .op_Imm_signal(b_imm), .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_ifl),
    .state(b_state), .stall_count(b_stall), .flush_count(b_flush)
  );

  // scoreboard
  logic [63:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: per instance, how many FLUSH cycles remain, whether the
  // front end is held, whether last cycle was the load-use bubble
  int          flush_len[2] = '{3, 1};
  logic [15:0] cnt_max[2]   = '{16'hFFFF, 16'h0007};
  int          m_flush_left[2];
  bit          m_lu[2], m_hold[2];
  logic [15:0] m_stall[2], m_flush[2];

  function automatic bit ref_load_use(logic [31:0] insn, logic mr, logic [4:0] rd);
    logic [6:0] op;
    bit use1, use2;
    op   = insn[6:0];
    use1 = !(op == O_LUI || op == O_AUIPC || op == O_JAL);
    use2 = (op == O_R || op == O_S || op == O_B);
    return mr && (rd != 5'd0) &&
           ((use1 && insn[19:15] == rd) || (use2 && insn[24:20] == rd));
  endfunction

  task automatic model_step(input int i);
    logic [63:0] bubble, passv;
    bit pass, pcw, ifw, fl;
    int st;
    bubble = {22'd0, NOP, 10'd0};
    passv  = {22'd0, ip_Instruction, ip_ALUSrc, ip_ALUOp, ip_MemRead, ip_MemWrite,
              ip_MemtoReg, ip_RegWrite, ip_Imm_signal};
    if (!reset) begin
      m_flush_left[i] = 0; m_lu[i] = 0; m_hold[i] = 0; m_stall[i] = '0; m_flush[i] = '0;
      exp_q.push_back(bubble);
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd0);
      return;
    end
    st = (m_flush_left[i] > 0) ? 2 : m_hold[i] ? 3 : m_lu[i] ? 1 : 0;
    pass = 0; pcw = 0; ifw = 0; fl = 0;
    if (m_flush_left[i] > 0) begin
      fl = 1;
      if (ex_branch_taken) m_flush_left[i] = flush_len[i] - 1;
      else m_flush_left[i]--;
    end else if (ex_branch_taken) begin
      fl = 1; pcw = 1;
      m_flush_left[i] = flush_len[i] - 1; m_hold[i] = 0; m_lu[i] = 0;
    end else if (ext_stall) begin
      m_hold[i] = 1; m_lu[i] = 0;
    end else if (!m_lu[i] && ref_load_use(ip_Instruction, ex_MemRead, ex_rd)) begin
      m_lu[i] = 1; m_hold[i] = 0;
    end else begin
      pass = 1; pcw = 1; ifw = 1; m_lu[i] = 0; m_hold[i] = 0;
    end
    exp_q.push_back(pass ? passv : bubble);
    exp_q.push_back({61'd0, pcw, ifw, fl});
    exp_q.push_back(64'(st));
    exp_q.push_back({48'd0, m_stall[i]});
    exp_q.push_back({48'd0, m_flush[i]});
    if (!pcw && m_stall[i] != cnt_max[i]) m_stall[i]++;
    if (ex_branch_taken && m_flush[i] != cnt_max[i]) m_flush[i]++;
  endtask

  function automatic logic [63:0] observe(int i, int k);
    case (k)
      0: return (i == 0) ? {22'd0, a_insn, a_alusrc, a_aluop, a_mr, a_mw, a_m2r, a_rw, a_imm}
                         : {22'd0, b_insn, b_alusrc, b_aluop, b_mr, b_mw, b_m2r, b_rw, b_imm};
      1: return (i == 0) ? {61'd0, a_pcw, a_ifw, a_ifl} : {61'd0, b_pcw, b_ifw, b_ifl};
      2: return (i == 0) ? {62'd0, a_state} : {62'd0, b_state};
      3: return (i == 0) ? {48'd0, a_stall} : {61'd0, b_stall};
      default: return (i == 0) ? {48'd0, a_flush} : {61'd0, b_flush};
    endcase
  endfunction

  string field_name[5] = '{"bundle", "enables", "state", "stall_count", "flush_count"};

  // called just after a rising edge; checks mid-phase, returns on the next rising edge
  task automatic do_cycle(input string tag);
    logic [63:0] e;
    #2;
    for (int i = 0; i < 2; i++) begin
      model_step(i);
      for (int k = 0; k < 5; k++) begin
        e = exp_q.pop_front();
        check_eq($sformatf("%s/%s/dut%0d", tag, field_name[k], i), observe(i, k), e);
      end
    end
    @(posedge clk);
  endtask

  // driver
  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                     logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, rd, op};
  endfunction

  task automatic drive(input logic [31:0] insn, input logic mr, input logic [4:0] rd,
                       input logic br, input logic st);
    ip_Instruction  = insn;
    ip_ALUSrc       = 2'($urandom_range(0, 3));
    ip_ALUOp        = 2'($urandom_range(0, 3));
    ip_MemtoReg     = 2'($urandom_range(0, 3));
    ip_MemRead      = 1'($urandom_range(0, 1));
    ip_MemWrite     = 1'($urandom_range(0, 1));
    ip_RegWrite     = 1'($urandom_range(0, 1));
    ip_Imm_signal   = 1'($urandom_range(0, 1));
    ex_MemRead      = mr;
    ex_rd           = rd;
    ex_branch_taken = br;
    ext_stall       = st;
  endtask

  logic [6:0] op_tab[8] = '{O_R, O_S, O_B, O_I, O_LD, O_LUI, O_AUIPC, O_JAL};
  logic [31:0] add_dep;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    add_dep = mk(O_R, 5'd6, 5'd5, 5'd7);
    reset = 1'b0;
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    do_cycle("reset_a");
    drive(add_dep, 1'b1, 5'd5, 1'b1, 1'b1);
    do_cycle("reset_b");
    reset = 1'b1;

    drive(add_dep, 1'b1, 5'd5, 1'b0, 1'b0);
    do_cycle("lu_bubble");
    do_cycle("lu_pass");
    drive(add_dep, 1'b0, 5'd0, 1'b0, 1'b0);
    do_cycle("lu_run");

    drive(mk(O_R, 5'd6, 5'd0, 5'd0), 1'b1, 5'd0, 1'b0, 1'b0);
    do_cycle("rd_zero");
    drive(mk(O_LUI, 5'd1, 5'd5, 5'd5), 1'b1, 5'd5, 1'b0, 1'b0);
    do_cycle("lui_nostall");
    drive(mk(O_S, 5'd0, 5'd1, 5'd5), 1'b1, 5'd5, 1'b0, 1'b0);
    do_cycle("sw_stall");
    do_cycle("sw_pass");

    drive(NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    do_cycle("branch");
    drive(add_dep, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) do_cycle($sformatf("flush%0d", n));

    drive(add_dep, 1'b1, 5'd5, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) do_cycle($sformatf("hold%0d", n));
    drive(add_dep, 1'b1, 5'd5, 1'b0, 1'b0);
    do_cycle("hold_lu");
    do_cycle("hold_pass");

    drive(add_dep, 1'b1, 5'd5, 1'b1, 1'b1);
    do_cycle("br_vs_stall");
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) do_cycle($sformatf("br_vs_stall_after%0d", n));

    drive(NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    do_cycle("br_again");
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    do_cycle("mid_flush");
    reset = 1'b0;
    do_cycle("reset_mid_flush");
    reset = 1'b1;
    do_cycle("after_reset");

    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int n = 0; n < 12; n++) do_cycle($sformatf("stall_sat%0d", n));
    drive(NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) do_cycle($sformatf("flush_sat%0d", n));

    for (int n = 0; n < 2000; n++) begin
      drive(mk(op_tab[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      reset = ($urandom_range(0, 99) != 0);
      do_cycle($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
